// File: rtl/z_csa_accum_ctrl_if.sv
// z_csa_accum_ctrl_if: operand stream, result handshake and abort control for the CSA accumulator
interface z_csa_accum_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ready;
    logic             busy;

    modport master (
        output clear, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, busy
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, busy
    );
endinterface

// File: rtl/z_csa_accum_ctrl.sv
// z_csa_accum_ctrl: carry-save accumulation of an operand set, resolved by iterative carry ripple
module z_csa_accum_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    z_csa_accum_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] s, c, s_n, c_n;
    logic [7:0]       cnt, cnt_n;
    logic [WIDTH-1:0] d;
    logic             accept;

    assign d             = bus.in_data;
    assign bus.in_ready  = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid = state == DONE;
    assign bus.out_sum   = (state == DONE) ? s : '0;
    assign bus.out_count = (state == DONE) ? cnt : 8'd0;
    assign bus.busy      = state != IDLE;
    assign accept        = bus.in_valid && bus.in_ready;

    // state and carry-save pair registers; rst dominates everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            c     <= '0;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            s     <= s_n;
            c     <= c_n;
            cnt   <= cnt_n;
        end
    end

    // next state: CSA stage on accept, carry ripple in RESOLVE, clear on handoff or abort
    always_comb begin
        state_n = state;
        s_n     = s;
        c_n     = c;
        cnt_n   = cnt;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    s_n     = s ^ c ^ d;
                    c_n     = ((s & c) | (s & d) | (c & d)) << 1;
                    cnt_n   = cnt + {7'd0, cnt != 8'hff};
                    state_n = bus.in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                if (c != '0) begin
                    s_n = s ^ c;
                    c_n = (s & c) << 1;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                    s_n     = '0;
                    c_n     = '0;
                    cnt_n   = 8'd0;
                end
            end
        endcase
        if (bus.clear) begin
            state_n = IDLE;
            s_n     = '0;
            c_n     = '0;
            cnt_n   = 8'd0;
        end
    end
endmodule

// File: tb/tb_z_csa_accum_ctrl.sv
// tb_z_csa_accum_ctrl: directed vectors with hand-computed sums, counts and resolve latencies
module tb_z_csa_accum_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   cyc;

    z_csa_accum_ctrl_if #(.WIDTH(8)) bus ();

    z_csa_accum_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        if (!bus.out_valid) check("done_timeout", 0, 1);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;

        send(8'd3, 1'b0);
        check("accum_busy", bus.busy, 1);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        check("resolve_in_ready", bus.in_ready, 0);
        wait_done(cyc);
        check("a_latency", cyc, 2);
        check("a_sum", bus.out_sum, 15);
        check("a_count", bus.out_count, 3);
        check("a_in_ready", bus.in_ready, 0);
        release_result();
        check("a_idle_valid", bus.out_valid, 0);
        check("a_idle_busy", bus.busy, 0);
        check("a_idle_sum", bus.out_sum, 0);

        send(8'd255, 1'b0);
        send(8'd1, 1'b1);
        wait_done(cyc);
        check("wrap_latency", cyc, 8);
        check("wrap_sum", bus.out_sum, 0);
        check("wrap_count", bus.out_count, 2);
        release_result();

        send(8'hA5, 1'b1);
        wait_done(cyc);
        check("single_latency", cyc, 1);
        check("single_sum", bus.out_sum, 8'hA5);
        check("single_count", bus.out_count, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd9;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_sum", bus.out_sum, 8'hA5);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("hold_count", bus.out_count, 1);
        release_result();
        check("hold_release_busy", bus.busy, 0);
        send(8'h10, 1'b1);
        wait_done(cyc);
        check("after_hold_sum", bus.out_sum, 8'h10);
        check("after_hold_count", bus.out_count, 1);
        release_result();

        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        rst = 1'b1;
        bus.clear = 1'b1;
        step();
        rst = 1'b0;
        bus.clear = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_sum", bus.out_sum, 0);
        check("midrst_count", bus.out_count, 0);
        check("midrst_busy", bus.busy, 0);
        send(8'd2, 1'b0);
        send(8'd2, 1'b1);
        wait_done(cyc);
        check("midrst_latency", cyc, 2);
        check("midrst_res_sum", bus.out_sum, 4);
        check("midrst_res_count", bus.out_count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done_rst_valid", bus.out_valid, 0);
        check("done_rst_busy", bus.busy, 0);

        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd50;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_busy", bus.busy, 0);
        send(8'd1, 1'b1);
        wait_done(cyc);
        check("clear_sum", bus.out_sum, 1);
        check("clear_count", bus.out_count, 1);
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        check("clear_done_valid", bus.out_valid, 0);

        for (int i = 0; i < 299; i++) send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        wait_done(cyc);
        check("sat_latency_bound", cyc <= 9, 1);
        check("sat_sum", bus.out_sum, 44);
        check("sat_count", bus.out_count, 255);
        release_result();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
